i2c_regfile_arbiter: RTL

- Shares the single-port register memory behind the I2C subordinate between two requesters: the I2C subordinate's byte-access port and a local host port (board switches/keys or soft logic).
- Sequences every memory access as issue, capture, acknowledge.
- Grants I2C by priority, with a starvation guard for the host.
- Drives a clock-stretch request so the subordinate holds SCL low while its access is pending.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_regfile_arbiter_if.sv | 49 ++++
 rtl/i2c_regfile_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register-file arbiter.
// Widths and FSM/owner encodings used by the arbiter and its bus.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        ACK
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I2C,
        OWN_HOST
    } arb_owner_t;

endpackage

// File: rtl/i2c_regfile_arbiter_if.sv
// Requester and memory signals of the register-file arbiter.
// slave = arbiter side, master = requesters plus memory.
interface i2c_regfile_arbiter_if
    import i2c_pkg::*;
#(
    parameter int ADDR_W = I2C_ADDR_W,
    parameter int DATA_W = I2C_DATA_W
);

    logic              i2c_req;
    logic              i2c_we;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_wdata;
    logic              i2c_ack;
    logic [DATA_W-1:0] i2c_rdata;
    logic              i2c_stretch;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i2c_req, i2c_we, i2c_addr, i2c_wdata,
        output i2c_ack, i2c_rdata, i2c_stretch,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i2c_req, i2c_we, i2c_addr, i2c_wdata,
        input  i2c_ack, i2c_rdata, i2c_stretch,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/i2c_regfile_arbiter.sv
// Arbitrates the single-port register memory between I2C and host.
// Each access runs IDLE -> ACCESS -> CAPTURE -> ACK.
module i2c_regfile_arbiter
    import i2c_pkg::*;
#(
    parameter int ADDR_W        = I2C_ADDR_W,
    parameter int DATA_W        = I2C_DATA_W,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_regfile_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    arb_state_t        state, state_d;
    arb_owner_t        owner, owner_d;
    logic [3:0]        wait_cnt, wait_d;
    logic              lat_we, we_d;
    logic [ADDR_W-1:0] lat_addr, addr_d;
    logic [DATA_W-1:0] lat_wdata, wdata_d;
    logic [DATA_W-1:0] i2c_rdata_q, host_rdata_q;
    logic              contested;
    logic              grant_host;

    assign contested  = bus.i2c_req && bus.host_req;
    // Host takes a contested slot only after enough consecutive losses
    assign grant_host = bus.host_req
                     && (!bus.i2c_req || wait_cnt >= MAX_WAIT);

    always_comb begin
        state_d = state;
        owner_d = owner;
        wait_d  = wait_cnt;
        we_d    = lat_we;
        addr_d  = lat_addr;
        wdata_d = lat_wdata;
        unique case (state)
            IDLE: begin
                owner_d = OWN_NONE;
                if (bus.i2c_req || bus.host_req) begin
                    state_d = ACCESS;
                    if (grant_host) begin
                        owner_d = OWN_HOST;
                        wait_d  = '0;
                        we_d    = bus.host_we;
                        addr_d  = bus.host_addr;
                        wdata_d = bus.host_wdata;
                    end else begin
                        owner_d = OWN_I2C;
                        if (contested && wait_cnt != 4'hF)
                            wait_d = wait_cnt + 4'd1;
                        we_d    = bus.i2c_we;
                        addr_d  = bus.i2c_addr;
                        wdata_d = bus.i2c_wdata;
                    end
                end
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            wait_cnt  <= wait_d;
            lat_we    <= we_d;
            lat_addr  <= addr_d;
            lat_wdata <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i2c_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else if (state == CAPTURE && !lat_we) begin
            if (owner == OWN_I2C)
                i2c_rdata_q <= bus.mem_rdata;
            else if (owner == OWN_HOST)
                host_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_en      = (state == ACCESS);
    assign bus.mem_we      = (state == ACCESS) && lat_we;
    assign bus.mem_addr    = lat_addr;
    assign bus.mem_wdata   = lat_wdata;
    assign bus.i2c_ack     = (state == ACK) && (owner == OWN_I2C);
    assign bus.host_ack    = (state == ACK) && (owner == OWN_HOST);
    assign bus.i2c_rdata   = i2c_rdata_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.i2c_stretch = bus.i2c_req
                          && !((owner == OWN_I2C) && (state == ACK));

endmodule
